fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage directly upstream of immediate generation and decode. Holds the program counter and issues one instruction-memory request at a time over a valid/ready handshake. Captures the returned word into a single-entry fetch/decode buffer and presents it as instruction, opcode and PC to decode, which passes opcode and instruction to imm_gen. Accepts a redirect (branch/jump target) that flushes in-flight work.

## Interface
- RESET_PC, 32'h0040_0000, first fetch address after reset
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- imem_req_valid  out  1  request to instruction memory
- imem_req_addr  out  32  request byte address (always word aligned)
- imem_req_ready  in  1  memory accepts request this cycle
- imem_rsp_valid  in  1  response word valid (at least 1 cycle after acceptance)
- imem_rsp_data  in  32  instruction word
- redirect_valid  in  1  load new PC, flush fetch/decode buffer
- redirect_pc  in  32  new PC; bits [1:0] ignored (forced 0)
- id_valid  out  1  buffer holds a valid instruction
- id_ready  in  1  decode consumes buffer this cycle
- id_instr  out  32  buffered instruction
- id_opcode  out  7  id_instr[6:0], combinational
- id_pc  out  32  address of id_instr

## Operation
- Registers: pc, req_pc, state, id_valid, id_instr, id_pc.
- States: IDLE, REQ, WAIT, DROP. At most one outstanding memory request.
- buf_free = !id_valid || id_ready.
- imem_req_valid = (state==REQ) && buf_free && !redirect_valid; imem_req_addr = pc.
- IDLE: next cycle -> REQ. Entered only from reset.
- REQ: on imem_req_valid && imem_req_ready: req_pc <= pc, -> WAIT. Otherwise stay.
- WAIT: on imem_rsp_valid: id_instr <= imem_rsp_data, id_pc <= req_pc, id_valid <= 1, pc <= req_pc + 4, -> REQ.
- DROP: on imem_rsp_valid: discard the data, -> REQ.
- Decode handshake: transfer when id_valid && id_ready; id_valid clears unless refilled in the same cycle. While id_valid && !id_ready, id_instr/id_pc/id_opcode are held stable.
- Redirect (highest priority, any state): pc <= {redirect_pc[31:2],2'b00}, id_valid <= 0.
  - REQ or IDLE: stay/go REQ. No request is issued in the redirect cycle.
  - WAIT without imem_rsp_valid: -> DROP.
  - WAIT or DROP with imem_rsp_valid in the same cycle: response discarded, -> REQ.
  - DROP without response: stay DROP, latest redirect_pc wins.
  - Redirect and id_ready in the same cycle: flush wins; the buffered instruction is considered consumed/killed.
- Arithmetic: pc+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000.

## Timing
- Reset values (asynchronous on rst_n low): state=IDLE, pc=RESET_PC, req_pc=0, id_valid=0, id_instr=32'h0000_0013 (NOP), id_pc=0. Therefore imem_req_valid=0 and id_opcode=7'h13.
- First request is issued in the second rising edge after rst_n deasserts (1 cycle in IDLE, then REQ).
- Latency, memory accept to id_valid: response cycle + 1 (registered capture).
- Peak throughput: one instruction per 2 cycles with single-cycle memory (REQ, WAIT).
- Reset asserted mid-transaction: all state is abandoned. A late memory response after reset arrives while in IDLE/REQ and is ignored (imem_rsp_valid is only sampled in WAIT/DROP).
- imem_req_addr is stable while imem_req_valid && !imem_req_ready, unless redirect_valid deasserts valid first.

## Test plan
- Reset, RESET_PC default, memory ready=1, 1-cycle response -> requests at 0x00400000, 0x00400004, 0x00400008. id_pc follows, id_valid pulses every 2 cycles, id_opcode = imem_rsp_data[6:0].
- Hold id_ready=0 for 5 cycles with buffer full -> imem_req_valid=0 throughout, id_instr/id_pc unchanged. Release -> next request in same cycle.
- Redirect to 0x00400103 while in WAIT, response 3 cycles later -> response dropped, id_valid=0, next request addr 0x00400100.
- Redirect coincident with imem_rsp_valid -> data discarded, id_valid=0 next cycle, next request at redirect target.
- Redirect to 0xFFFFFFFC, response returned -> id_pc=0xFFFFFFFC, next request 0x00000000.
- Assert rst_n low while in WAIT, then respond during reset and after release -> no id_valid, first request at RESET_PC after the IDLE cycle.

Source files
------------

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage. Holds the program counter, issues one instruction
// memory request at a time over a valid/ready handshake, captures the returned
// word into a single-entry fetch/decode buffer and presents it to decode.
// A redirect loads a new PC and flushes the buffer and any in-flight request.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   imem_req_valid/addr request to instruction memory (word-aligned address)
//   imem_req_ready      memory accepts the request this cycle
//   imem_rsp_valid/data response word from memory
//   redirect_valid/pc   load new PC (bits [1:0] forced to zero), flush
//   id_valid/id_ready   fetch/decode buffer handshake
//   id_instr/opcode/pc  buffered instruction, its opcode field and address
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [6:0]  id_opcode,
  output logic [31:0] id_pc
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DROP
  } state_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic        buf_free;

  // Low address bits of a redirect target are ignored by design.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    id_valid_d = id_valid_q;
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;

    // A request may only go out when its response is guaranteed a free slot.
    buf_free       = !id_valid_q || id_ready;
    imem_req_valid = (state_q == REQ) && buf_free && !redirect_valid;

    if (id_valid_q && id_ready) begin
      id_valid_d = 1'b0;
    end

    if (redirect_valid) begin
      // Flush has priority over everything, including a same-cycle decode
      // transfer and a same-cycle memory response.
      pc_d       = {redirect_pc[31:2], 2'b00};
      id_valid_d = 1'b0;
      unique case (state_q)
        WAIT, DROP: state_d = imem_rsp_valid ? REQ : DROP;
        default:    state_d = REQ;
      endcase
    end else begin
      unique case (state_q)
        IDLE: state_d = REQ;
        REQ: begin
          if (imem_req_valid && imem_req_ready) begin
            req_pc_d = pc_q;
            state_d  = WAIT;
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            id_instr_d = imem_rsp_data;
            id_pc_d    = req_pc_q;
            id_valid_d = 1'b1;
            pc_d       = req_pc_q + 32'd4;
            state_d    = REQ;
          end
        end
        DROP: begin
          if (imem_rsp_valid) begin
            state_d = REQ;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      id_valid_q <= 1'b0;
      id_instr_q <= NOP;
      id_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      id_valid_q <= id_valid_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
    end
  end

  assign imem_req_addr = pc_q;
  assign id_valid      = id_valid_q;
  assign id_instr      = id_instr_q;
  assign id_opcode     = id_instr_q[6:0];
  assign id_pc         = id_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Drives fetch_unit with a behavioural instruction memory and a transaction
// level reference model (expected next fetch address, outstanding request,
// expected buffer contents). Inputs change on the falling edge; outputs are
// sampled 1 time unit later, before the next rising edge.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [6:0]  id_opcode;
  logic [31:0] id_pc;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_opcode      (id_opcode),
    .id_pc          (id_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Stimulus controls
  logic        t_rst_n    = 1'b0;
  logic        t_id_ready = 1'b1;
  logic        t_redirect = 1'b0;
  logic [31:0] t_rpc      = '0;
  int          ready_pct  = 100;
  int          lat_min    = 1;
  int          lat_max    = 1;
  logic        force_rsp  = 1'b0;

  // Memory model state
  logic        mem_busy = 1'b0;
  logic [31:0] mem_addr = '0;
  int          mem_cnt  = 0;
  logic [31:0] req_log[$];

  // Reference model state
  logic        m_started   = 1'b0;
  logic [31:0] m_exp_addr  = RST_PC;
  logic        m_pend      = 1'b0;
  logic [31:0] m_pend_addr = '0;
  logic        m_killed    = 1'b0;
  logic        m_buf_valid = 1'b0;
  logic [31:0] m_buf_pc    = '0;
  logic [31:0] m_buf_instr = 32'h13;

  // Samples taken before each rising edge
  logic        s_req_valid, s_accept, s_id_valid;
  logic [31:0] s_req_addr, s_id_instr, s_id_pc;
  logic [6:0]  s_opcode;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic        rsp;
    logic [31:0] data;
    logic        exp_req;
    @(negedge clk);
    rst_n          = t_rst_n;
    id_ready       = t_id_ready;
    redirect_valid = t_redirect;
    redirect_pc    = t_rpc;
    rsp  = 1'b0;
    data = $urandom;
    if (force_rsp) begin
      rsp = 1'b1;
    end else if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        rsp      = 1'b1;
        data     = mem_word(mem_addr);
        mem_busy = 1'b0;
      end
    end
    imem_rsp_valid = rsp;
    imem_rsp_data  = data;
    imem_req_ready = ($urandom_range(99) < ready_pct);
    #1;
    s_req_valid = imem_req_valid;
    s_req_addr  = imem_req_addr;
    s_id_valid  = id_valid;
    s_id_instr  = id_instr;
    s_id_pc     = id_pc;
    s_opcode    = id_opcode;
    s_accept    = imem_req_valid && imem_req_ready;

    if (!t_rst_n) begin
      m_started   = 1'b0;
      m_exp_addr  = RST_PC;
      m_pend      = 1'b0;
      m_killed    = 1'b0;
      m_buf_valid = 1'b0;
    end

    chk("id_valid", {31'b0, s_id_valid}, {31'b0, m_buf_valid});
    if (m_buf_valid) begin
      chk("id_pc", s_id_pc, m_buf_pc);
      chk("id_instr", s_id_instr, m_buf_instr);
      chk("id_opcode", {25'b0, s_opcode}, {25'b0, m_buf_instr[6:0]});
    end
    if (!t_rst_n) begin
      chk("rst_id_instr", s_id_instr, 32'h13);
      chk("rst_id_pc", s_id_pc, 32'h0);
      chk("rst_opcode", {25'b0, s_opcode}, 32'h13);
    end
    exp_req = t_rst_n && m_started && !m_pend && (!m_buf_valid || t_id_ready) && !t_redirect;
    chk("req_valid", {31'b0, s_req_valid}, {31'b0, exp_req});
    if (exp_req) chk("req_addr", s_req_addr, m_exp_addr);

    // Memory side: accept based on what the DUT actually presents.
    if (s_accept) begin
      mem_busy = 1'b1;
      mem_addr = s_req_addr;
      mem_cnt  = $urandom_range(lat_max, lat_min);
      req_log.push_back(s_req_addr);
    end

    // Model update for the coming rising edge.
    if (t_rst_n) begin
      m_started = 1'b1;
      if (t_redirect) begin
        m_exp_addr  = t_rpc & 32'hFFFF_FFFC;
        m_buf_valid = 1'b0;
        if (m_pend) begin
          if (rsp) begin
            m_pend   = 1'b0;
            m_killed = 1'b0;
          end else begin
            m_killed = 1'b1;
          end
        end
      end else begin
        if (m_buf_valid && t_id_ready) m_buf_valid = 1'b0;
        if (rsp && m_pend) begin
          if (!m_killed) begin
            m_buf_valid = 1'b1;
            m_buf_pc    = m_pend_addr;
            m_buf_instr = mem_word(m_pend_addr);
            m_exp_addr  = m_pend_addr + 32'd4;
          end
          m_pend   = 1'b0;
          m_killed = 1'b0;
        end
        if (exp_req && imem_req_ready) begin
          m_pend      = 1'b1;
          m_pend_addr = m_exp_addr;
          m_killed    = 1'b0;
        end
      end
    end
  endtask

  task automatic wait_accept(input string tag);
    logic got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      got = s_accept;
    end
    chk(tag, {31'b0, got}, 32'd1);
  endtask

  task automatic wait_idv(input string tag);
    logic got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      got = s_id_valid;
    end
    chk(tag, {31'b0, got}, 32'd1);
  endtask

  initial begin
    logic [31:0] snap_instr, snap_pc, addr;
    logic        saw_idv, got;

    rst_n = 1'b0; id_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;

    // Reset state
    tick(); tick();
    chk("rst_req_valid", {31'b0, s_req_valid}, 32'd0);
    chk("rst_id_valid", {31'b0, s_id_valid}, 32'd0);

    // Streaming with single-cycle memory
    t_rst_n = 1'b1;
    tick();
    chk("idle_no_req", {31'b0, s_req_valid}, 32'd0);
    tick();
    chk("first_req", {31'b0, s_req_valid}, 32'd1);
    chk("first_addr", s_req_addr, 32'h0040_0000);
    tick();
    chk("stream_idv0", {31'b0, s_id_valid}, 32'd0);
    tick();
    chk("stream_idv1", {31'b0, s_id_valid}, 32'd1);
    chk("stream_pc0", s_id_pc, 32'h0040_0000);
    chk("stream_op0", {25'b0, s_opcode}, {25'b0, mem_word(32'h0040_0000) & 32'h7F});
    tick();
    chk("stream_idv2", {31'b0, s_id_valid}, 32'd0);
    tick();
    chk("stream_idv3", {31'b0, s_id_valid}, 32'd1);
    chk("stream_pc1", s_id_pc, 32'h0040_0004);
    chk("req_log_n", req_log.size(), 32'd3);
    if (req_log.size() >= 3) begin
      chk("req_log0", req_log[0], 32'h0040_0000);
      chk("req_log1", req_log[1], 32'h0040_0004);
      chk("req_log2", req_log[2], 32'h0040_0008);
    end

    // Decode back-pressure
    t_id_ready = 1'b0;
    wait_idv("hold_fill");
    snap_instr = s_id_instr;
    snap_pc    = s_id_pc;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_no_req", {31'b0, s_req_valid}, 32'd0);
      chk("hold_instr", s_id_instr, snap_instr);
      chk("hold_pc", s_id_pc, snap_pc);
    end
    t_id_ready = 1'b1;
    tick();
    chk("release_req", {31'b0, s_req_valid}, 32'd1);

    // Redirect while waiting, response arrives three cycles later
    lat_min = 4; lat_max = 4;
    wait_accept("rd1_accept");
    t_redirect = 1'b1; t_rpc = 32'h0040_0103;
    tick();
    t_redirect = 1'b0;
    saw_idv = 1'b0; got = 1'b0; addr = '0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      saw_idv = saw_idv | s_id_valid;
      got = s_req_valid;
      addr = s_req_addr;
    end
    chk("rd1_req_seen", {31'b0, got}, 32'd1);
    chk("rd1_no_idv", {31'b0, saw_idv}, 32'd0);
    chk("rd1_addr", addr, 32'h0040_0100);

    // Redirect coincident with the memory response
    lat_min = 2; lat_max = 2;
    wait_accept("rd2_accept");
    tick();
    t_redirect = 1'b1; t_rpc = 32'h0040_1000;
    tick();
    t_redirect = 1'b0;
    tick();
    chk("rd2_idv", {31'b0, s_id_valid}, 32'd0);
    chk("rd2_req", {31'b0, s_req_valid}, 32'd1);
    chk("rd2_addr", s_req_addr, 32'h0040_1000);

    // Wrap at the top of the address space
    lat_min = 1; lat_max = 1;
    t_redirect = 1'b1; t_rpc = 32'hFFFF_FFFE;
    tick();
    t_redirect = 1'b0;
    wait_idv("wrap_idv");
    chk("wrap_id_pc", s_id_pc, 32'hFFFF_FFFC);
    chk("wrap_instr", s_id_instr, mem_word(32'hFFFF_FFFC));
    chk("wrap_req", {31'b0, s_req_valid}, 32'd1);
    chk("wrap_addr", s_req_addr, 32'h0000_0000);

    // Reset while a request is outstanding, stray responses around release
    lat_min = 6; lat_max = 6;
    wait_accept("rst_accept");
    tick();
    t_rst_n = 1'b0; mem_busy = 1'b0; force_rsp = 1'b1;
    tick();
    tick();
    chk("rstmid_idv", {31'b0, s_id_valid}, 32'd0);
    t_rst_n = 1'b1; ready_pct = 0;
    tick();
    chk("rstrel_idle", {31'b0, s_req_valid}, 32'd0);
    tick();
    chk("rstrel_req", {31'b0, s_req_valid}, 32'd1);
    chk("rstrel_addr", s_req_addr, RST_PC);
    chk("rstrel_idv", {31'b0, s_id_valid}, 32'd0);
    force_rsp = 1'b0; ready_pct = 100; lat_min = 1; lat_max = 3;
    wait_idv("rstrel_fill");
    chk("rstrel_first_pc", s_id_pc, RST_PC);

    // Randomized traffic against the reference model
    ready_pct = 60; lat_min = 1; lat_max = 4;
    for (int i = 0; i < 2000; i++) begin
      t_id_ready = ($urandom_range(3) != 0);
      t_redirect = ($urandom_range(19) == 0);
      t_rpc      = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(15)) : $urandom;
      tick();
    end
    t_redirect = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
